// File: rtl/anujic_pkg.sv
`default_nettype none
// ============================================================================
// Module   : anujic_pkg
// Brief    : Opcodes, flag bit positions and pad constants for the
//            tt_um_anujic accumulator ALU tile.
// Revision : 1.0
// ============================================================================
package anujic_pkg;

    localparam int unsigned ALU_WIDTH = 8;
    localparam int unsigned OP_WIDTH  = 3;

    localparam logic [OP_WIDTH-1:0] OP_LOAD = 3'd0;
    localparam logic [OP_WIDTH-1:0] OP_ADD  = 3'd1;
    localparam logic [OP_WIDTH-1:0] OP_SUB  = 3'd2;
    localparam logic [OP_WIDTH-1:0] OP_AND  = 3'd3;
    localparam logic [OP_WIDTH-1:0] OP_OR   = 3'd4;
    localparam logic [OP_WIDTH-1:0] OP_XOR  = 3'd5;
    localparam logic [OP_WIDTH-1:0] OP_SHL  = 3'd6;
    localparam logic [OP_WIDTH-1:0] OP_SHR  = 3'd7;

    // Bit positions of the status flags inside uio_out
    localparam int unsigned FLAG_Z = 4;
    localparam int unsigned FLAG_C = 5;
    localparam int unsigned FLAG_N = 6;
    localparam int unsigned FLAG_V = 7;

    localparam int unsigned EXEC_BIT = 3;

    localparam logic [7:0] UIO_OE_MASK = 8'hF0;

    typedef struct packed {
        logic v;
        logic n;
        logic c;
        logic z;
    } flags_t;

endpackage : anujic_pkg
`default_nettype wire

// File: rtl/anujic_if.sv
`default_nettype none
// ============================================================================
// Module   : anujic_if
// Brief    : Tiny Tapeout pad bundle of the tile (enable, user and
//            bidirectional pins); master drives the inputs, slave the outputs.
// Revision : 1.0
// ============================================================================
interface anujic_if;

    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    modport master (
        output ena,
        output ui_in,
        output uio_in,
        input  uo_out,
        input  uio_out,
        input  uio_oe
    );

    modport slave (
        input  ena,
        input  ui_in,
        input  uio_in,
        output uo_out,
        output uio_out,
        output uio_oe
    );

endinterface : anujic_if
`default_nettype wire

// File: rtl/anujic_alu.sv
`default_nettype none
// ============================================================================
// Module   : anujic_alu
// Brief    : Combinational accumulator ALU: result plus carry/borrow and
//            signed-overflow for the eight opcodes.
// Revision : 1.0
// ============================================================================
module anujic_alu
    import anujic_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0]    i_a,
    input  logic [WIDTH-1:0]    i_b,
    input  logic [OP_WIDTH-1:0] i_op,
    output logic [WIDTH-1:0]    o_result,
    output logic                o_c,
    output logic                o_v
);

    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_diff;

    // The extra MSB of the difference is the unsigned borrow
    assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
    assign w_diff = {1'b0, i_a} - {1'b0, i_b};

    always_comb begin
        o_result = i_a;
        o_c      = 1'b0;
        o_v      = 1'b0;
        case (i_op)
            OP_LOAD: o_result = i_b;
            OP_ADD: begin
                o_result = w_sum[WIDTH-1:0];
                o_c      = w_sum[WIDTH];
                o_v      = (i_a[WIDTH-1] == i_b[WIDTH-1]) &&
                           (w_sum[WIDTH-1] != i_a[WIDTH-1]);
            end
            OP_SUB: begin
                o_result = w_diff[WIDTH-1:0];
                o_c      = w_diff[WIDTH];
                o_v      = (i_a[WIDTH-1] != i_b[WIDTH-1]) &&
                           (w_diff[WIDTH-1] != i_a[WIDTH-1]);
            end
            OP_AND: o_result = i_a & i_b;
            OP_OR:  o_result = i_a | i_b;
            OP_XOR: o_result = i_a ^ i_b;
            OP_SHL: begin
                o_result = {i_a[WIDTH-2:0], 1'b0};
                o_c      = i_a[WIDTH-1];
            end
            OP_SHR: begin
                o_result = {1'b0, i_a[WIDTH-1:1]};
                o_c      = i_a[0];
            end
            default: o_result = i_a;
        endcase
    end

endmodule : anujic_alu
`default_nettype wire

// File: rtl/tt_um_anujic.sv
`default_nettype none
// ============================================================================
// Module   : tt_um_anujic
// Brief    : Tiny Tapeout tile wrapping an 8-bit accumulator ALU; holds the
//            accumulator and flag registers and maps them onto the pads.
// Revision : 1.0
// ============================================================================
module tt_um_anujic
    import anujic_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe,
    input  logic       ena,
    input  logic       clk,
    input  logic       rst_n
);

    logic [WIDTH-1:0] r_acc;
    flags_t           r_flags;

    logic [WIDTH-1:0] w_result;
    logic             w_c;
    logic             w_v;
    logic             w_fire;
    logic             w_unused;

    assign w_fire   = ena && uio_in[EXEC_BIT];
    assign w_unused = &{1'b0, uio_in[7:4]};

    anujic_alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .i_a      (r_acc),
        .i_b      (ui_in[WIDTH-1:0]),
        .i_op     (uio_in[OP_WIDTH-1:0]),
        .o_result (w_result),
        .o_c      (w_c),
        .o_v      (w_v)
    );

    // rst_n is an active-high synchronous reset on this tile
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_acc   <= '0;
            r_flags <= '{v: 1'b0, n: 1'b0, c: 1'b0, z: 1'b1};
        end else if (w_fire) begin
            r_acc     <= w_result;
            r_flags.v <= w_v;
            r_flags.c <= w_c;
            r_flags.n <= w_result[WIDTH-1];
            r_flags.z <= (w_result == '0);
        end
    end

    always_comb begin
        uio_out         = '0;
        uio_out[FLAG_V] = r_flags.v;
        uio_out[FLAG_N] = r_flags.n;
        uio_out[FLAG_C] = r_flags.c;
        uio_out[FLAG_Z] = r_flags.z;
    end

    assign uo_out = r_acc;
    assign uio_oe = UIO_OE_MASK;

endmodule : tt_um_anujic
`default_nettype wire

// File: tb/tb_tt_um_anujic.sv
`default_nettype none
// ============================================================================
// Module   : tb_tt_um_anujic
// Brief    : Directed-vector scoreboard bench for the accumulator ALU tile.
// Revision : 1.0
// ============================================================================
module tb_tt_um_anujic;

    logic clk;
    logic rst_n;
    int   cyc;

    anujic_if pads ();

    tt_um_anujic dut (
        .ui_in   (pads.ui_in),
        .uo_out  (pads.uo_out),
        .uio_in  (pads.uio_in),
        .uio_out (pads.uio_out),
        .uio_oe  (pads.uio_oe),
        .ena     (pads.ena),
        .clk     (clk),
        .rst_n   (rst_n)
    );

    typedef struct {
        logic [2:0] op;
        logic [7:0] b;
        logic       exec;
        logic       ena;
        logic       rst;
        logic [3:0] hi;
        logic [7:0] exp_uo;
        logic [7:0] exp_uio;
    } vec_t;

    typedef struct {
        int         idx;
        int         cyc;
        logic [7:0] exp_uo;
        logic [7:0] exp_uio;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   n_applied;
    int   n_miscompares;

    localparam int NVEC = 37;
    vec_t vecs [NVEC];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    // Monitor: one registered result per cycle, checked mid-cycle
    always @(negedge clk) begin
        if (q.size() > 0 && q[0].cyc == cyc) begin
            mon_e = q.pop_front();
            n_applied++;
            if (pads.uo_out !== mon_e.exp_uo || pads.uio_out !== mon_e.exp_uio ||
                pads.uio_oe !== 8'hF0) begin
                n_miscompares++;
                $display("FAIL vec%0d: got uo_out=%02h uio_out=%02h uio_oe=%02h, want uo_out=%02h uio_out=%02h uio_oe=f0",
                         mon_e.idx, pads.uo_out, pads.uio_out, pads.uio_oe,
                         mon_e.exp_uo, mon_e.exp_uio);
            end
        end
    end

    initial begin
        //            op    b      ex    en    rst   hi     uo     uio
        vecs[0]  = '{3'd0, 8'h00, 1'b0, 1'b1, 1'b1, 4'h0, 8'h00, 8'h10}; // reset
        vecs[1]  = '{3'd0, 8'h00, 1'b0, 1'b1, 1'b1, 4'h0, 8'h00, 8'h10};
        vecs[2]  = '{3'd0, 8'h7F, 1'b1, 1'b1, 1'b0, 4'h0, 8'h7F, 8'h00}; // LOAD 7F
        vecs[3]  = '{3'd1, 8'h01, 1'b1, 1'b1, 1'b0, 4'h0, 8'h80, 8'hC0}; // ADD 01 -> V,N
        vecs[4]  = '{3'd0, 8'hFF, 1'b1, 1'b1, 1'b0, 4'h0, 8'hFF, 8'h40}; // LOAD FF
        vecs[5]  = '{3'd1, 8'h01, 1'b1, 1'b1, 1'b0, 4'h0, 8'h00, 8'h30}; // ADD -> C,Z
        vecs[6]  = '{3'd0, 8'h05, 1'b1, 1'b1, 1'b0, 4'h0, 8'h05, 8'h00}; // LOAD 05
        vecs[7]  = '{3'd2, 8'h06, 1'b1, 1'b1, 1'b0, 4'h0, 8'hFF, 8'h60}; // SUB borrow
        vecs[8]  = '{3'd1, 8'h10, 1'b0, 1'b1, 1'b0, 4'h0, 8'hFF, 8'h60}; // exec=0 hold
        vecs[9]  = '{3'd1, 8'h10, 1'b0, 1'b1, 1'b0, 4'h0, 8'hFF, 8'h60};
        vecs[10] = '{3'd1, 8'h10, 1'b0, 1'b1, 1'b0, 4'hF, 8'hFF, 8'h60}; // junk upper nibble
        vecs[11] = '{3'd1, 8'h10, 1'b1, 1'b0, 1'b0, 4'h0, 8'hFF, 8'h60}; // ena=0 hold
        vecs[12] = '{3'd1, 8'h10, 1'b1, 1'b0, 1'b0, 4'h0, 8'hFF, 8'h60};
        vecs[13] = '{3'd1, 8'h10, 1'b1, 1'b1, 1'b1, 4'h0, 8'h00, 8'h10}; // reset beats exec
        vecs[14] = '{3'd0, 8'h81, 1'b1, 1'b1, 1'b0, 4'h0, 8'h81, 8'h40}; // LOAD 81
        vecs[15] = '{3'd6, 8'hAA, 1'b1, 1'b1, 1'b0, 4'h0, 8'h02, 8'h20}; // SHL
        vecs[16] = '{3'd7, 8'h55, 1'b1, 1'b1, 1'b0, 4'h0, 8'h01, 8'h00}; // SHR
        vecs[17] = '{3'd5, 8'h01, 1'b1, 1'b1, 1'b0, 4'h0, 8'h00, 8'h10}; // XOR -> Z
        vecs[18] = '{3'd4, 8'hF0, 1'b1, 1'b1, 1'b0, 4'h0, 8'hF0, 8'h40}; // OR -> N
        vecs[19] = '{3'd3, 8'h3C, 1'b1, 1'b1, 1'b0, 4'h0, 8'h30, 8'h00}; // AND
        vecs[20] = '{3'd0, 8'h80, 1'b1, 1'b1, 1'b0, 4'h0, 8'h80, 8'h40}; // LOAD 80
        vecs[21] = '{3'd2, 8'h01, 1'b1, 1'b1, 1'b0, 4'h0, 8'h7F, 8'h80}; // SUB -> V
        vecs[22] = '{3'd0, 8'h03, 1'b1, 1'b1, 1'b0, 4'h0, 8'h03, 8'h00}; // LOAD 03
        vecs[23] = '{3'd7, 8'h00, 1'b1, 1'b1, 1'b0, 4'h0, 8'h01, 8'h20}; // SHR -> C
        vecs[24] = '{3'd0, 8'h80, 1'b1, 1'b1, 1'b0, 4'h0, 8'h80, 8'h40}; // LOAD 80
        vecs[25] = '{3'd6, 8'h00, 1'b1, 1'b1, 1'b0, 4'h0, 8'h00, 8'h30}; // SHL -> C,Z
        vecs[26] = '{3'd0, 8'h10, 1'b1, 1'b1, 1'b0, 4'h0, 8'h10, 8'h00}; // LOAD 10
        vecs[27] = '{3'd1, 8'h20, 1'b1, 1'b1, 1'b0, 4'h0, 8'h30, 8'h00}; // ADD 20
        vecs[28] = '{3'd1, 8'h01, 1'b1, 1'b1, 1'b0, 4'h0, 8'h31, 8'h00}; // held exec
        vecs[29] = '{3'd1, 8'h01, 1'b1, 1'b1, 1'b0, 4'h0, 8'h32, 8'h00};
        vecs[30] = '{3'd1, 8'h01, 1'b1, 1'b1, 1'b0, 4'h0, 8'h33, 8'h00};
        vecs[31] = '{3'd2, 8'h33, 1'b1, 1'b1, 1'b0, 4'h0, 8'h00, 8'h10}; // SUB -> Z, no borrow
        vecs[32] = '{3'd2, 8'h01, 1'b1, 1'b1, 1'b0, 4'h0, 8'hFF, 8'h60}; // 00-01 borrow
        vecs[33] = '{3'd1, 8'h80, 1'b1, 1'b1, 1'b0, 4'h0, 8'h7F, 8'hA0}; // FF+80 -> C,V
        vecs[34] = '{3'd3, 8'h00, 1'b1, 1'b0, 1'b1, 4'h0, 8'h00, 8'h10}; // reset beats ena=0
        vecs[35] = '{3'd1, 8'h7F, 1'b1, 1'b1, 1'b0, 4'h0, 8'h7F, 8'h00}; // ADD from 0
        vecs[36] = '{3'd1, 8'h7F, 1'b1, 1'b1, 1'b0, 4'h0, 8'hFE, 8'hC0}; // 7F+7F -> V,N
    end

    initial begin
        cyc           = 0;
        n_applied     = 0;
        n_miscompares = 0;
        rst_n         = 1'b1;
        pads.ena      = 1'b0;
        pads.ui_in    = 8'h00;
        pads.uio_in   = 8'h00;

        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            rst_n       = vecs[i].rst;
            pads.ena    = vecs[i].ena;
            pads.ui_in  = vecs[i].b;
            pads.uio_in = {vecs[i].hi, vecs[i].exec, vecs[i].op};
            q.push_back('{idx: i, cyc: cyc + 1,
                          exp_uo: vecs[i].exp_uo, exp_uio: vecs[i].exp_uio});
        end

        @(negedge clk);
        pads.uio_in = 8'h00;
        for (int k = 0; k < 10 && q.size() > 0; k++) @(negedge clk);
        if (q.size() > 0) begin
            $display("FAIL drain: got %0d unchecked vectors, want 0", q.size());
            n_miscompares += q.size();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miscompares);
        $finish;
    end

endmodule : tb_tt_um_anujic
`default_nettype wire
